// File: rtl/midi_parser.sv
// midi_parser: byte-level MIDI decoder with running status and channel filter.
// One byte per strobe; emits a registered one-cycle event for note off/on,
// control change and pitch bend. Real-time bytes pass through untouched.
module midi_parser #(
    parameter int CHANNEL = 0,
    parameter bit OMNI    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid_i,
    input  logic [7:0] byte_data_i,
    output logic       event_valid_o,
    output logic [1:0] event_type_o,
    output logic [3:0] event_channel_o,
    output logic [6:0] event_data1_o,
    output logic [6:0] event_data2_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2,
        SYSEX   = 2'd3
    } state_t;

    localparam logic [3:0] CHAN_SEL = 4'(CHANNEL);

    state_t     state_q;
    logic [2:0] rs_cmd_q;   // status high nibble minus 8 (0x8 -> 0 ... 0xE -> 6)
    logic [3:0] rs_chan_q;
    logic       rs_valid_q;
    logic [6:0] d1_q;

    logic       is_status;
    logic       is_rt;
    logic       is_sys;
    logic       two_byte;
    logic       chan_ok;
    logic       emit_ok;
    logic [1:0] ev_type_d;

    // Byte classification and event decode for the currently held command
    always_comb begin
        is_status = byte_data_i[7];
        is_rt     = byte_data_i[7:3] == 5'b11111;
        is_sys    = byte_data_i[7:3] == 5'b11110;
        // Program change (0xC) and channel pressure (0xD) carry one data byte
        two_byte  = (rs_cmd_q != 3'd4) && (rs_cmd_q != 3'd5);
        chan_ok   = OMNI || (rs_chan_q == CHAN_SEL);
        // Poly pressure (0xA) parses but never produces an event
        emit_ok   = chan_ok && ((rs_cmd_q == 3'd0) || (rs_cmd_q == 3'd1) ||
                                (rs_cmd_q == 3'd3) || (rs_cmd_q == 3'd6));
        ev_type_d = 2'd3;
        case (rs_cmd_q)
            3'd0:    ev_type_d = 2'd0;
            3'd1:    ev_type_d = (byte_data_i[6:0] == 7'd0) ? 2'd0 : 2'd1;
            3'd3:    ev_type_d = 2'd2;
            default: ev_type_d = 2'd3;
        endcase
    end

    // Parser FSM with running status; event outputs are registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            rs_cmd_q        <= 3'd0;
            rs_chan_q       <= 4'd0;
            rs_valid_q      <= 1'b0;
            d1_q            <= 7'd0;
            event_valid_o   <= 1'b0;
            event_type_o    <= 2'd0;
            event_channel_o <= 4'd0;
            event_data1_o   <= 7'd0;
            event_data2_o   <= 7'd0;
        end else begin
            event_valid_o <= 1'b0;
            if (byte_valid_i) begin
                if (is_status) begin
                    if (is_rt) begin
                        // Real-time bytes may land anywhere; leave everything as is
                    end else if (is_sys) begin
                        rs_valid_q <= 1'b0;
                        state_q    <= (byte_data_i[2:0] == 3'd0) ? SYSEX : IDLE;
                    end else begin
                        // Channel status always restarts the message, even mid-way
                        rs_cmd_q   <= byte_data_i[6:4];
                        rs_chan_q  <= byte_data_i[3:0];
                        rs_valid_q <= 1'b1;
                        state_q    <= WAIT_D1;
                    end
                end else begin
                    case (state_q)
                        WAIT_D1: begin
                            if (rs_valid_q && two_byte) begin
                                d1_q    <= byte_data_i[6:0];
                                state_q <= WAIT_D2;
                            end
                        end
                        WAIT_D2: begin
                            state_q <= WAIT_D1;
                            if (rs_valid_q && emit_ok) begin
                                event_valid_o   <= 1'b1;
                                event_type_o    <= ev_type_d;
                                event_channel_o <= rs_chan_q;
                                event_data1_o   <= d1_q;
                                event_data2_o   <= byte_data_i[6:0];
                            end
                        end
                        default: begin
                            // IDLE and SYSEX swallow data bytes
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_parser.sv
// tb_midi_parser: directed vector table, reset corner cases and a randomized
// byte stream checked against a message-level reference model. Two parsers
// share the stimulus: one omni, one filtered to channel 2.
module tb_midi_parser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bv  = 1'b0;
    logic [7:0] bd  = 8'h00;

    logic       ev  [2];
    logic [1:0] ety [2];
    logic [3:0] ech [2];
    logic [6:0] ed1 [2];
    logic [6:0] ed2 [2];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    midi_parser #(.CHANNEL(0), .OMNI(1'b1)) u_omni (
        .clk(clk), .rst(rst), .byte_valid_i(bv), .byte_data_i(bd),
        .event_valid_o(ev[0]), .event_type_o(ety[0]), .event_channel_o(ech[0]),
        .event_data1_o(ed1[0]), .event_data2_o(ed2[0])
    );

    midi_parser #(.CHANNEL(2), .OMNI(1'b0)) u_ch2 (
        .clk(clk), .rst(rst), .byte_valid_i(bv), .byte_data_i(bd),
        .event_valid_o(ev[1]), .event_type_o(ety[1]), .event_channel_o(ech[1]),
        .event_data1_o(ed1[1]), .event_data2_o(ed2[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("%s dut%0d valid", nm, m), 32'(ev[m]), 0);
            chk($sformatf("%s dut%0d fields", nm, m),
                {12'd0, ety[m], ech[m], ed1[m], ed2[m]}, 0);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [7:0] b;
        logic       ev0;
        logic       ev1;
        logic [1:0] ty;
        logic [3:0] ch;
        logic [6:0] d1;
        logic [6:0] d2;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [7:0] b, input logic e0, input logic e1,
                                input logic [1:0] ty, input logic [3:0] ch,
                                input logic [6:0] d1, input logic [6:0] d2);
        vec_t v;
        v.b = b; v.ev0 = e0; v.ev1 = e1; v.ty = ty; v.ch = ch; v.d1 = d1; v.d2 = d2;
        tbl.push_back(v);
    endfunction

    function automatic void add0(input logic [7:0] b);
        add(b, 1'b0, 1'b0, 2'd0, 4'd0, 7'd0, 7'd0);
    endfunction

    task automatic chk_vec(input int i);
        vec_t v;
        logic [31:0] exp_f;
        v = tbl[i];
        exp_f = {12'd0, v.ty, v.ch, v.d1, v.d2};
        chk($sformatf("vec%0d omni valid", i), 32'(ev[0]), 32'(v.ev0));
        chk($sformatf("vec%0d ch2 valid", i), 32'(ev[1]), 32'(v.ev1));
        if (v.ev0) chk($sformatf("vec%0d omni fields", i),
                       {12'd0, ety[0], ech[0], ed1[0], ed2[0]}, exp_f);
        if (v.ev1) chk($sformatf("vec%0d ch2 fields", i),
                       {12'd0, ety[1], ech[1], ed1[1], ed2[1]}, exp_f);
    endtask

    // ---------------- reference model (message level) ----------------
    int         rs [2];   // running status byte, 0 when none
    int         nd [2];   // data bytes collected for the current message
    logic [6:0] fd [2];   // first data byte
    logic       mv [2];
    logic [1:0] mty[2];
    logic [3:0] mch[2];
    logic [6:0] md1[2];
    logic [6:0] md2[2];

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            rs[m] = 0; nd[m] = 0; fd[m] = 0; mv[m] = 0;
            mty[m] = 0; mch[m] = 0; md1[m] = 0; md2[m] = 0;
        end
    endfunction

    function automatic void model_idle();
        mv[0] = 0; mv[1] = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        int hi, need;
        for (int m = 0; m < 2; m++) begin
            mv[m] = 0;
            if (b >= 8'hF8) begin
            end else if (b >= 8'hF0) begin
                rs[m] = 0; nd[m] = 0;
            end else if (b >= 8'h80) begin
                rs[m] = int'(b); nd[m] = 0;
            end else if (rs[m] != 0) begin
                hi   = rs[m] / 16;
                need = (hi == 12 || hi == 13) ? 1 : 2;
                nd[m]++;
                if (nd[m] == 1) fd[m] = b[6:0];
                if (nd[m] == need) begin
                    nd[m] = 0;
                    if (need == 2 && hi != 10 && (m == 0 || rs[m] % 16 == 2)) begin
                        mv[m]  = 1;
                        mch[m] = 4'(rs[m] % 16);
                        md1[m] = fd[m];
                        md2[m] = b[6:0];
                        if (hi == 8)       mty[m] = 0;
                        else if (hi == 9)  mty[m] = (b == 0) ? 2'd0 : 2'd1;
                        else if (hi == 11) mty[m] = 2;
                        else               mty[m] = 3;
                    end
                end
            end
        end
    endfunction

    task automatic chk_model(input int cyc);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("rnd%0d dut%0d valid", cyc, m), 32'(ev[m]), 32'(mv[m]));
            chk($sformatf("rnd%0d dut%0d fields", cyc, m),
                {12'd0, ety[m], ech[m], ed1[m], ed2[m]},
                {12'd0, mty[m], mch[m], md1[m], md2[m]});
        end
    endtask

    task automatic send_one(input logic [7:0] b);
        @(negedge clk);
        bv = 1'b1; bd = b;
        @(negedge clk);
        bv = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // Pending event cleared immediately by async reset
        send_one(8'h90);
        send_one(8'h3C);
        send_one(8'h64);
        chk("pre-reset pulse", 32'(ev[0]), 1);
        #1 rst = 1'b1;
        #1 chk_zero("async reset");
        @(negedge clk);
        rst = 1'b0;

        // Reset between 0x80 and its data loses the message
        send_one(8'h80);
        #2 rst = 1'b1;
        #1 chk_zero("mid-msg reset");
        #2 rst = 1'b0;
        send_one(8'h3C);
        chk("post-reset d1 omni", 32'(ev[0]), 0);
        send_one(8'h00);
        chk("post-reset d2 omni", 32'(ev[0]), 0);
        chk("post-reset d2 ch2", 32'(ev[1]), 0);

        // Directed table, applied back-to-back
        add0(8'h55);
        add0(8'h90); add0(8'h3C); add(8'h64, 1, 0, 2'd1, 4'd0, 7'h3C, 7'h64);
        add0(8'h93); add0(8'h40); add(8'h7F, 1, 0, 2'd1, 4'd3, 7'h40, 7'h7F);
        add0(8'h40); add(8'h00, 1, 0, 2'd0, 4'd3, 7'h40, 7'h00);
        add0(8'hB1); add0(8'hF8); add0(8'h07); add0(8'hFE);
        add(8'h55, 1, 0, 2'd2, 4'd1, 7'h07, 7'h55);
        add0(8'h90); add0(8'h3C); add0(8'hF0); add0(8'h01);
        add0(8'h02); add0(8'hF7); add0(8'h3C); add0(8'h40);
        add0(8'hC2); add0(8'h05); add0(8'hE5); add0(8'h00);
        add(8'h40, 1, 0, 2'd3, 4'd5, 7'h00, 7'h40);
        add0(8'hE2); add0(8'h00); add(8'h40, 1, 1, 2'd3, 4'd2, 7'h00, 7'h40);
        add0(8'hA2); add0(8'h10); add0(8'h20); add0(8'h10); add0(8'h20);
        add0(8'hD2); add0(8'h01); add0(8'h02);
        add0(8'h92); add0(8'h3C); add(8'h00, 1, 1, 2'd0, 4'd2, 7'h3C, 7'h00);
        add0(8'h3C); add(8'h45, 1, 1, 2'd1, 4'd2, 7'h3C, 7'h45);
        add0(8'h8F); add0(8'h11); add0(8'hF9); add(8'h22, 1, 0, 2'd0, 4'hF, 7'h11, 7'h22);
        add0(8'h90); add0(8'h3C); add0(8'hB2); add0(8'h07);
        add(8'h7F, 1, 1, 2'd2, 4'd2, 7'h07, 7'h7F);

        for (int i = 0; i <= tbl.size(); i++) begin
            @(negedge clk);
            if (i > 0) chk_vec(i - 1);
            if (i < tbl.size()) begin
                bv = 1'b1; bd = tbl[i].b;
            end else begin
                bv = 1'b0;
            end
        end
        @(negedge clk);
        chk("table tail omni valid", 32'(ev[0]), 0);
        chk("table tail fields hold", {25'd0, ed1[1]}, 32'h07);

        // Randomized stream against the reference model
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [7:0] b;
            int r;
            @(negedge clk);
            chk_model(c);
            if ($urandom_range(0, 3) == 0) begin
                bv = 1'b0;
                bd = 8'($urandom);
                model_idle();
            end else begin
                r = $urandom_range(0, 99);
                if (r < 50)      b = 8'($urandom_range(0, 127));
                else if (r < 78) b = 8'($urandom_range(8'h80, 8'hEF));
                else if (r < 90) b = 8'($urandom_range(8'hF8, 8'hFF));
                else             b = 8'($urandom_range(8'hF0, 8'hF7));
                bv = 1'b1;
                bd = b;
                model_byte(b);
            end
        end
        @(negedge clk);
        chk_model(3000);
        bv = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/midi_parser.md
# midi_parser

Byte-level MIDI message parser between the serial receiver and the voice/player logic. Consumes one received byte per strobe, tracks running status, filters by channel, and emits single-cycle decoded events (note off, note on, control change, pitch bend) with channel and two 7-bit data fields. Other messages, SysEx payloads and real-time bytes are absorbed without disturbing decode state.

## Interface

Parameters:
- `CHANNEL`, 0: MIDI channel (0–15) accepted when `OMNI` = 0.
- `OMNI`, 1: 1 = accept all channels; 0 = accept only `CHANNEL`.

Ports:
- `clk`  in  1  system clock (16 MHz); one clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `byte_valid`  in  1  one-cycle strobe; `byte_data` valid this cycle.
- `byte_data`  in  8  received MIDI byte.
- `event_valid`  out  1  one-cycle pulse; event fields valid this cycle.
- `event_type`  out  2  0 = note off, 1 = note on, 2 = control change, 3 = pitch bend.
- `event_channel`  out  4  channel of the message.
- `event_data1`  out  7  note number / controller number / pitch-bend LSB.
- `event_data2`  out  7  velocity / controller value / pitch-bend MSB.

## Operation

- Byte classes: status = bit 7 set; data = bit 7 clear; real-time = 0xF8–0xFF; system common/SysEx = 0xF0–0xF7.
- Registers: running status (`rs_cmd[2:0]`, `rs_chan[3:0]`, `rs_valid`), first data byte `d1[6:0]`, state.
- States: IDLE (no running status), WAIT_D1, WAIT_D2, SYSEX.
- Real-time byte: ignored in every state; no state, data or running-status change.
- Channel status 0x80–0xEF (any state, including mid-message): load running status, `rs_valid` = 1, discard any partial message, go WAIT_D1.
- 0xF0: clear `rs_valid`, go SYSEX. 0xF1–0xF7: clear `rs_valid`, go IDLE.
- SYSEX: data bytes ignored; leave only on a status byte (handled as above; 0xF7 → IDLE).
- IDLE: data bytes ignored.
- WAIT_D1 + data: two-byte-payload commands (0x8, 0x9, 0xA, 0xB, 0xE) store `d1`, go WAIT_D2; one-byte commands (0xC, 0xD) complete with no event, stay WAIT_D1 (running status).
- WAIT_D2 + data: message complete; go WAIT_D1 (running status retained). Emit event if command is 0x8/0x9/0xB/0xE and channel passes filter (`OMNI` = 1 or `rs_chan` = `CHANNEL`). 0xA (poly pressure) emits nothing.
- Mapping: 0x8 → type 0; 0x9 → type 1, except data2 = 0 → type 0; 0xB → type 2; 0xE → type 3.
- Filtered-out messages parse normally (running status preserved), emit nothing.

## Timing

- Reset: `event_valid` = 0, `event_type` = 0, `event_channel` = 0, `event_data1` = 0, `event_data2` = 0; state IDLE; `rs_valid` = 0; `d1` = 0.
- Latency: `event_valid` high exactly the cycle after the `byte_valid` cycle of the completing data byte; all outputs registered.
- `event_valid` is a 1-cycle pulse; event fields hold last values until the next event.
- Back-to-back `byte_valid` on consecutive cycles supported; at most one event per byte.
- `byte_data` ignored when `byte_valid` = 0.
- Reset asserted mid-message: partial message and running status lost; any pending `event_valid` cleared immediately.

## Test plan

- Note on: 0x90, 0x3C, 0x64 → one pulse, type 1, ch 0, d1 0x3C, d2 0x64, one cycle after the third strobe.
- Running status + velocity-0: 0x93, 0x40, 0x7F, 0x40, 0x00 → two events: (type 1, ch 3, 0x40, 0x7F) then (type 0, ch 3, 0x40, 0x00).
- Real-time interleave: 0xB1, 0xF8, 0x07, 0xFE, 0x55 → one event type 2, ch 1, d1 0x07, d2 0x55.
- Interrupted/SysEx: 0x90, 0x3C, 0xF0, 0x01, 0x02, 0xF7, 0x3C, 0x40 → no events (running status cleared by 0xF0).
- Filter and one-byte cmds: `OMNI` = 0, `CHANNEL` = 2; 0xC2, 0x05, 0xE5, 0x00, 0x40, 0xE2, 0x00, 0x40 → single event type 3, ch 2, d1 0x00, d2 0x40.
- Async reset between 0x80 and 0x3C, then 0x3C, 0x00 → no event; all outputs 0 during reset.
